ay_access_scheduler: RTL and testbench
======================================

AY_ACCESS_SCHEDULER -- requirements
Module: ay_access_scheduler

Interface
REQ-001 clk28  input  1  system clock, 28 MHz; all logic on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 en  input  1  sound subsystem enable; low = scheduler idle, requests dropped.
REQ-004 cpu_addr_wr  input  1  one-cycle pulse: CPU register-select write (port FFFD).
REQ-005 cpu_data_wr  input  1  one-cycle pulse: CPU data write (port BFFD).
REQ-006 cpu_sel  input  1  chip currently selected by CPU (0/1).
REQ-007 cpu_d  input  8  CPU data, valid with either pulse.
REQ-008 req  input  1  internal requester write request, held until ack.
REQ-009 req_chip  input  1  target chip of internal request.
REQ-010 req_reg  input  4  target register of internal request.
REQ-011 req_data  input  8  data of internal request.
REQ-012 ack  output  1  one-cycle pulse: internal request completed or dropped.
REQ-013 ay_addr_stb  output  1  one-cycle address-latch strobe to the sound chip bus.
REQ-014 ay_we_stb  output  1  one-cycle data-write strobe to the sound chip bus.
REQ-015 ay_sel  output  1  chip select qualifying both strobes.
REQ-016 ay_d  output  8  data qualifying both strobes.
REQ-017 busy  output  1  high whenever state is not IDLE or a CPU event is pending.

Function
REQ-018 All outputs registered; one strobe maximum per cycle; strobes never both high.
REQ-019 States: IDLE, CPU_ADDR, CPU_DATA, INT_ADDR, INT_DATA, RESTORE; each non-IDLE state lasts exactly one cycle.
REQ-020 CPU pulses captured into pending_addr / pending_data flags (with cpu_sel, cpu_d) in the cycle they arrive, in any state.
REQ-021 Repeated pulse of same kind while pending overwrites captured sel/data (latest wins).
REQ-022 CPU address capture updates shadow_reg[cpu_sel] <= cpu_d immediately.
REQ-023 IDLE priority: pending_addr > pending_data > req.
REQ-024 CPU_ADDR: ay_addr_stb=1, ay_d=captured data, ay_sel=captured sel; clears pending_addr.
REQ-025 CPU_DATA: ay_we_stb=1 likewise; clears pending_data.
REQ-026 Internal sequence is atomic: INT_ADDR (addr stb, ay_d={4'h0,req_reg}) -> INT_DATA (we stb, ay_d=req_data) -> RESTORE (addr stb, ay_d=shadow_reg[req_chip]) -> IDLE.
REQ-027 ack pulses in the RESTORE cycle; req fields are sampled in IDLE and held internally.
REQ-028 Latency from IDLE with nothing pending: CPU pulse at cycle N -> strobe at N+1; req at N -> strobes N+1, N+2, N+3, ack N+3.
REQ-029 CPU pulse during an internal sequence waits; worst-case CPU strobe latency 4 cycles.
REQ-030 CPU pulse and req in same IDLE cycle: CPU served first, req served after pending flags clear.
REQ-031 en low: next state IDLE, pending flags cleared, no strobes; req asserted with en low acked next cycle without strobes; shadow retained.
REQ-032 en falling mid-sequence aborts at next edge; ack issued for aborted internal request.

Reset
REQ-033 Reset: state IDLE, all strobes/ack/busy 0, ay_sel 0, ay_d 8'h00, pending flags 0, shadow_reg[0..1] 8'h00.

Configuration
REQ-034 Macro TURBOSOUND_EN defined: two chips, ay_sel follows cpu_sel/req_chip, two shadow registers.
REQ-035 TURBOSOUND_EN undefined: ay_sel constant 0, single shadow; CPU events with cpu_sel=1 ignored; req with req_chip=1 acked next cycle without strobes.

Structure
REQ-036 State enum type and state width go in package common; no other shared constants.
REQ-037 Single flat module; no sub-module.

Verification
REQ-038 cpu_addr_wr, cpu_d=8'h07, sel 0 -> ay_addr_stb next cycle, ay_d=8'h07, shadow_reg[0]=8'h07.
REQ-039 shadow_reg[1]=8'h08, req chip1 reg 4'hA data 8'h55 -> addr 8'h0A, we 8'h55, addr 8'h08 on consecutive cycles, ack with last.
REQ-040 cpu_data_wr 8'h3C one cycle after req accepted -> we stb with 8'h3C exactly after RESTORE (cycle N+4).
REQ-041 Simultaneous cpu_addr_wr (8'h01) and req in IDLE -> CPU addr stb first, then internal 3-strobe sequence, restore uses 8'h01.
REQ-042 en dropped in INT_DATA -> no RESTORE strobe, ack pulse, busy 0 next cycle; rst_n low mid-sequence -> all outputs reset values.

Source files
------------

// File: rtl/ay_access_scheduler_pkg.sv
// Shared types for the AY sound-chip bus access scheduler.
// Holds only the scheduler state encoding and its width.
package common;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_ADDR = 3'd1,
        ST_CPU_DATA = 3'd2,
        ST_INT_ADDR = 3'd3,
        ST_INT_DATA = 3'd4,
        ST_RESTORE  = 3'd5
    } state_t;

endpackage

// File: rtl/ay_access_scheduler.sv
// AY sound-chip bus access scheduler.
// Merges CPU register-select / data writes with an internal requester onto a
// single strobe bus. An internal write is an atomic three-strobe sequence
// (select register, write data, restore the CPU's register select) so the CPU
// never observes its selected register change underneath it.
// Build option: define TURBOSOUND_EN for two chips (ay_sel follows the
// requester); when undefined a single chip is assumed and chip-1 traffic is
// ignored (CPU) or acknowledged without bus activity (internal).
module ay_access_scheduler
    import common::*;
(
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cpu_addr_wr,
    input  logic       cpu_data_wr,
    input  logic       cpu_sel,
    input  logic [7:0] cpu_d,
    input  logic       req,
    input  logic       req_chip,
    input  logic [3:0] req_reg,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic       ay_addr_stb,
    output logic       ay_we_stb,
    output logic       ay_sel,
    output logic [7:0] ay_d,
    output logic       busy
);

`ifdef TURBOSOUND_EN
    localparam bit TURBO = 1'b1;
`else
    localparam bit TURBO = 1'b0;
`endif

    // A chip index is only reachable when the second chip exists.
    function automatic logic chip_ok(input logic sel);
        return TURBO || !sel;
    endfunction

    state_t     state_q, state_d;
    logic       pa_q, pa_d, pa_sel_q, pa_sel_d;
    logic [7:0] pa_dat_q, pa_dat_d;
    logic       pd_q, pd_d, pd_sel_q, pd_sel_d;
    logic [7:0] pd_dat_q, pd_dat_d;
    logic       rq_chip_q, rq_chip_d;
    logic [3:0] rq_reg_q, rq_reg_d;
    logic [7:0] rq_data_q, rq_data_d;
    logic       ack_q, ack_d;
    logic       addr_stb_q, addr_stb_d;
    logic       we_stb_q, we_stb_d;
    logic       sel_q, sel_d;
    logic [7:0] d_q, d_d;
    logic       busy_q, busy_d;

    logic       a_in, d_in;
    logic       dispatch;
    logic [7:0] restore_val;

`ifdef TURBOSOUND_EN
    logic [7:0] shadow_q [2];
`else
    logic [7:0] shadow_q;
`endif

    // Restore value is the CPU's last register select for the active chip.
    always_comb begin
`ifdef TURBOSOUND_EN
        restore_val = shadow_q[rq_chip_q];
`else
        restore_val = shadow_q;
`endif
    end

    // Next-state, pending-capture and registered-output decisions.
    always_comb begin
        a_in = en && cpu_addr_wr && chip_ok(cpu_sel);
        d_in = en && cpu_data_wr && chip_ok(cpu_sel);

        // Capture incoming CPU pulses; the newest pulse of a kind wins.
        pa_d     = pa_q | a_in;
        pa_sel_d = a_in ? cpu_sel : pa_sel_q;
        pa_dat_d = a_in ? cpu_d : pa_dat_q;
        pd_d     = pd_q | d_in;
        pd_sel_d = d_in ? cpu_sel : pd_sel_q;
        pd_dat_d = d_in ? cpu_d : pd_dat_q;

        state_d    = state_q;
        rq_chip_d  = rq_chip_q;
        rq_reg_d   = rq_reg_q;
        rq_data_d  = rq_data_q;
        ack_d      = 1'b0;
        addr_stb_d = 1'b0;
        we_stb_d   = 1'b0;
        sel_d      = sel_q;
        d_d        = d_q;
        dispatch   = 1'b0;

        if (!en) begin
            // Disabled: drop everything; any live or newly offered internal
            // request is acknowledged once so the requester can move on.
            state_d = ST_IDLE;
            pa_d    = 1'b0;
            pd_d    = 1'b0;
            ack_d   = !ack_q && (req || state_q == ST_INT_ADDR || state_q == ST_INT_DATA);
        end else begin
            unique case (state_q)
                ST_INT_ADDR: begin
                    state_d  = ST_INT_DATA;
                    we_stb_d = 1'b1;
                    sel_d    = rq_chip_q;
                    d_d      = rq_data_q;
                end
                ST_INT_DATA: begin
                    state_d    = ST_RESTORE;
                    addr_stb_d = 1'b1;
                    sel_d      = rq_chip_q;
                    d_d        = restore_val;
                    ack_d      = 1'b1;
                end
                default: dispatch = 1'b1;
            endcase

            // Every terminal state picks the next job directly, so a queued
            // CPU event follows RESTORE with no idle gap. The request still
            // visible during its own ack cycle must not be taken twice.
            if (dispatch) begin
                state_d = ST_IDLE;
                if (pa_d) begin
                    state_d    = ST_CPU_ADDR;
                    addr_stb_d = 1'b1;
                    sel_d      = pa_sel_d;
                    d_d        = pa_dat_d;
                    pa_d       = 1'b0;
                end else if (pd_d) begin
                    state_d  = ST_CPU_DATA;
                    we_stb_d = 1'b1;
                    sel_d    = pd_sel_d;
                    d_d      = pd_dat_d;
                    pd_d     = 1'b0;
                end else if (req && !ack_q) begin
                    if (chip_ok(req_chip)) begin
                        state_d    = ST_INT_ADDR;
                        addr_stb_d = 1'b1;
                        sel_d      = req_chip;
                        d_d        = {4'h0, req_reg};
                        rq_chip_d  = req_chip;
                        rq_reg_d   = req_reg;
                        rq_data_d  = req_data;
                    end else begin
                        ack_d = 1'b1;
                    end
                end
            end
        end

        if (!TURBO) begin
            sel_d     = 1'b0;
            rq_chip_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE) || pa_d || pd_d;
    end

    // Scheduler state, pending flags and all bus outputs.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pa_q       <= 1'b0;
            pa_sel_q   <= 1'b0;
            pa_dat_q   <= 8'h00;
            pd_q       <= 1'b0;
            pd_sel_q   <= 1'b0;
            pd_dat_q   <= 8'h00;
            rq_chip_q  <= 1'b0;
            rq_reg_q   <= 4'h0;
            rq_data_q  <= 8'h00;
            ack_q      <= 1'b0;
            addr_stb_q <= 1'b0;
            we_stb_q   <= 1'b0;
            sel_q      <= 1'b0;
            d_q        <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pa_q       <= pa_d;
            pa_sel_q   <= pa_sel_d;
            pa_dat_q   <= pa_dat_d;
            pd_q       <= pd_d;
            pd_sel_q   <= pd_sel_d;
            pd_dat_q   <= pd_dat_d;
            rq_chip_q  <= rq_chip_d;
            rq_reg_q   <= rq_reg_d;
            rq_data_q  <= rq_data_d;
            ack_q      <= ack_d;
            addr_stb_q <= addr_stb_d;
            we_stb_q   <= we_stb_d;
            sel_q      <= sel_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
        end
    end

    // Shadow of the CPU's register select, updated the moment it is written.
`ifdef TURBOSOUND_EN
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q[0] <= 8'h00;
            shadow_q[1] <= 8'h00;
        end else if (a_in) begin
            shadow_q[cpu_sel] <= cpu_d;
        end
    end
`else
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 8'h00;
        end else if (a_in) begin
            shadow_q <= cpu_d;
        end
    end
`endif

    assign ack         = ack_q;
    assign ay_addr_stb = addr_stb_q;
    assign ay_we_stb   = we_stb_q;
    assign ay_sel      = sel_q;
    assign ay_d        = d_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ay_access_scheduler.sv
// Self-checking bench for ay_access_scheduler: table-driven single
// transactions plus hand-written multi-cycle sequences, with every bus event
// checked against a queue of expected {cycle, strobes, sel, data, ack}.
module tb_ay_access_scheduler;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cpu_addr_wr, cpu_data_wr, cpu_sel;
    logic [7:0] cpu_d;
    logic       req, req_chip;
    logic [3:0] req_reg;
    logic [7:0] req_data;
    logic       ack, ay_addr_stb, ay_we_stb, ay_sel, busy;
    logic [7:0] ay_d;

    always #5 clk28 = ~clk28;

    ay_access_scheduler dut (
        .clk28(clk28), .rst_n(rst_n), .en(en),
        .cpu_addr_wr(cpu_addr_wr), .cpu_data_wr(cpu_data_wr), .cpu_sel(cpu_sel), .cpu_d(cpu_d),
        .req(req), .req_chip(req_chip), .req_reg(req_reg), .req_data(req_data),
        .ack(ack), .ay_addr_stb(ay_addr_stb), .ay_we_stb(ay_we_stb),
        .ay_sel(ay_sel), .ay_d(ay_d), .busy(busy)
    );

    typedef struct {
        int         cyc;
        logic       addr;
        logic       we;
        logic       sel;
        logic [7:0] d;
        logic       ack;
    } ev_t;

    typedef struct {
        logic [1:0] kind;     // 0 cpu addr, 1 cpu data, 2 internal req
        logic       sel;      // cpu_sel or req_chip
        logic [7:0] d;        // cpu_d
        logic [3:0] rg;
        logic [7:0] dat;
        logic       noev;     // expect no bus activity at all
        logic       ackonly;  // expect a bare ack one cycle later
        logic [7:0] rest;     // expected restore value
    } vec_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    vec_t vecs[8];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk28) cyc <= cyc + 1;

    // Every strobe/ack cycle is one transaction against the expected queue.
    always @(negedge clk28) begin
        if (rst_n === 1'b1 && (ay_addr_stb || ay_we_stb || ack)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d addr=%b we=%b sel=%b d=%h ack=%b",
                         cyc, ay_addr_stb, ay_we_stb, ay_sel, ay_d, ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || ay_addr_stb != mon_e.addr || ay_we_stb != mon_e.we ||
                    ack != mon_e.ack ||
                    ((ay_addr_stb || ay_we_stb) && (ay_sel != mon_e.sel || ay_d != mon_e.d))) begin
                    errors++;
                    $display("FAIL bus_event got cyc=%0d addr=%b we=%b sel=%b d=%h ack=%b want cyc=%0d addr=%b we=%b sel=%b d=%h ack=%b",
                             cyc, ay_addr_stb, ay_we_stb, ay_sel, ay_d, ack,
                             mon_e.cyc, mon_e.addr, mon_e.we, mon_e.sel, mon_e.d, mon_e.ack);
                end else begin
                    $display("event cyc=%0d addr=%b we=%b sel=%b d=%h ack=%b ok",
                             cyc, ay_addr_stb, ay_we_stb, ay_sel, ay_d, ack);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic push_ev(input int c, input logic a, input logic w, input logic s,
                           input logic [7:0] d, input logic k);
        ev_t e;
        e.cyc = c; e.addr = a; e.we = w; e.sel = s; e.d = d; e.ack = k;
        exp_q.push_back(e);
    endtask

    // Advance one cycle; pulses last one cycle; requester drops req on ack.
    task automatic tick();
        @(posedge clk28);
        #1;
        cpu_addr_wr = 1'b0;
        cpu_data_wr = 1'b0;
        if (ack) req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!busy && !req && exp_q.size() == 0) done = 1;
            else tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout busy=%b req=%b pending_events=%0d want idle", name, busy, req, exp_q.size());
            exp_q.delete();
            req = 1'b0;
        end
        tick();
    endtask

    task automatic start_req(input logic chip, input logic [3:0] rg, input logic [7:0] dat);
        req = 1'b1; req_chip = chip; req_reg = rg; req_data = dat;
    endtask

    task automatic push_int(input int n, input logic chip, input logic [3:0] rg,
                            input logic [7:0] dat, input logic [7:0] rest);
        push_ev(n + 1, 1'b1, 1'b0, chip, {4'h0, rg}, 1'b0);
        push_ev(n + 2, 1'b0, 1'b1, chip, dat, 1'b0);
        push_ev(n + 3, 1'b1, 1'b0, chip, rest, 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b1;
        cpu_addr_wr = 0; cpu_data_wr = 0; cpu_sel = 0; cpu_d = 8'h00;
        req = 0; req_chip = 0; req_reg = 4'h0; req_data = 8'h00;

        vecs[0] = '{2'd0, 1'b0, 8'h07, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{2'd1, 1'b0, 8'hA5, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{2'd2, 1'b0, 8'h00, 4'hA, 8'h55, 1'b0, 1'b0, 8'h07};
        vecs[3] = '{2'd0, 1'b0, 8'h0E, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{2'd2, 1'b0, 8'h00, 4'h3, 8'hC3, 1'b0, 1'b0, 8'h0E};
`ifdef TURBOSOUND_EN
        vecs[5] = '{2'd0, 1'b1, 8'h08, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{2'd2, 1'b1, 8'h00, 4'hA, 8'h55, 1'b0, 1'b0, 8'h08};
`else
        vecs[5] = '{2'd0, 1'b1, 8'h99, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{2'd2, 1'b1, 8'h00, 4'h2, 8'h11, 1'b0, 1'b1, 8'h00};
`endif
        vecs[7] = '{2'd2, 1'b0, 8'h00, 4'hF, 8'hFF, 1'b0, 1'b0, 8'h0E};

        // Reset values, during and just after reset
        repeat (3) @(posedge clk28);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ay_d", ay_d, 8'h00);
        @(negedge clk28);
        rst_n = 1'b1;
        tick();
        chk("post_rst_strobes", {ack, ay_addr_stb, ay_we_stb, ay_sel}, 0);
        chk("post_rst_busy", busy, 0);

        // Table-driven single transactions from idle
        for (int i = 0; i < 8; i++) begin
            n = cyc;
            if (vecs[i].kind == 2'd2) begin
                start_req(vecs[i].sel, vecs[i].rg, vecs[i].dat);
            end else begin
                cpu_sel = vecs[i].sel;
                cpu_d   = vecs[i].d;
                if (vecs[i].kind == 2'd0) cpu_addr_wr = 1'b1;
                else cpu_data_wr = 1'b1;
            end
            if (vecs[i].ackonly) push_ev(n + 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            else if (vecs[i].noev) ;
            else if (vecs[i].kind == 2'd0) push_ev(n + 1, 1'b1, 1'b0, vecs[i].sel, vecs[i].d, 1'b0);
            else if (vecs[i].kind == 2'd1) push_ev(n + 1, 1'b0, 1'b1, vecs[i].sel, vecs[i].d, 1'b0);
            else push_int(n, vecs[i].sel, vecs[i].rg, vecs[i].dat, vecs[i].rest);
            tick();
            if (!vecs[i].noev && !vecs[i].ackonly) chk($sformatf("vec%0d_busy", i), busy, 1);
            cpu_sel = 1'b0;
            wait_idle($sformatf("vec%0d", i));
        end

        // CPU data write queued behind an internal sequence
        n = cyc;
        start_req(1'b0, 4'h5, 8'h66);
        push_int(n, 1'b0, 4'h5, 8'h66, 8'h0E);
        push_ev(n + 4, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0);
        tick();
        cpu_data_wr = 1'b1; cpu_d = 8'h3C;
        tick();
        wait_idle("cpu_behind_int");

        // Simultaneous CPU address write and request: CPU first
        n = cyc;
        cpu_addr_wr = 1'b1; cpu_d = 8'h01;
        start_req(1'b0, 4'h9, 8'h77);
        push_ev(n + 1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
        push_int(n + 1, 1'b0, 4'h9, 8'h77, 8'h01);
        tick();
        wait_idle("cpu_and_req");

        // Enable dropped during INT_DATA aborts with a bare ack
        n = cyc;
        start_req(1'b0, 4'h4, 8'h44);
        push_ev(n + 1, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0);
        push_ev(n + 2, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0);
        push_ev(n + 3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_no_strobe", {ay_addr_stb, ay_we_stb}, 0);
        en = 1'b1;
        wait_idle("abort");

        // Request offered while disabled is acked without strobes
        en = 1'b0;
        n = cyc;
        start_req(1'b0, 4'h1, 8'h12);
        push_ev(n + 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        en = 1'b1;
        wait_idle("disabled_req");

        // Asynchronous reset in the middle of a sequence
        n = cyc;
        start_req(1'b0, 4'h6, 8'h21);
        push_ev(n + 1, 1'b1, 1'b0, 1'b0, 8'h06, 1'b0);
        tick();
        @(negedge clk28);
        #1;
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        chk("midrst_outputs", {ack, ay_addr_stb, ay_we_stb, ay_sel, busy}, 0);
        chk("midrst_ay_d", ay_d, 8'h00);
        repeat (2) @(posedge clk28);
        @(negedge clk28);
        rst_n = 1'b1;
        tick();
        chk("midrst_queue", exp_q.size(), 0);

        // Shadow cleared by reset: restore after reset uses 8'h00
        n = cyc;
        start_req(1'b0, 4'hB, 8'h5A);
        push_int(n, 1'b0, 4'hB, 8'h5A, 8'h00);
        tick();
        wait_idle("post_rst_req");

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
